// File: rtl/mux_result_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_result_packer : packs serial result bits into WIDTH-bit words with
// flush of partial words and full valid/ready backpressure.  Rev 1.0
// ---------------------------------------------------------------------------
module mux_result_packer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(WIDTH+1)-1:0] dout_cnt,
  output logic                       dout_valid,
  input  logic                       dout_ready
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FILL       = 2'd1,
    FULL_WAIT  = 2'd2,
    FLUSH_WAIT = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sreg, sreg_nx, word_nx, load_word;
  logic [CW-1:0]    cnt, cnt_nx, cnt_inc, pos, load_cnt;
  logic             beat, slot_free, load;

  assign w_ready   = !rst && ((state == IDLE) || (state == FILL));
  assign beat      = w_valid && w_ready;
  assign slot_free = !dout_valid || dout_ready;
  assign cnt_inc   = cnt + {{(CW-1){1'b0}}, beat};
  assign pos       = MSB_FIRST ? (FULL - ONE - cnt) : cnt;

  // Bits are written straight to their final position, so a partial word is
  // already aligned and its unfilled positions remain zero.
  always_comb begin
    word_nx = sreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (beat && (pos == CW'(i))) begin
        word_nx[i] = w;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    sreg_nx   = sreg;
    cnt_nx    = cnt;
    load      = 1'b0;
    load_word = sreg;
    load_cnt  = cnt;
    case (state)
      IDLE, FILL: begin
        if (cnt_inc == FULL) begin
          if (slot_free) begin
            load      = 1'b1;
            load_word = word_nx;
            load_cnt  = FULL;
            sreg_nx   = '0;
            cnt_nx    = '0;
            state_nx  = IDLE;
          end else begin
            sreg_nx  = word_nx;
            cnt_nx   = FULL;
            state_nx = FULL_WAIT;
          end
        end else if (flush && (cnt_inc != '0)) begin
          if (slot_free) begin
            load      = 1'b1;
            load_word = word_nx;
            load_cnt  = cnt_inc;
            sreg_nx   = '0;
            cnt_nx    = '0;
            state_nx  = IDLE;
          end else begin
            sreg_nx  = word_nx;
            cnt_nx   = cnt_inc;
            state_nx = FLUSH_WAIT;
          end
        end else begin
          sreg_nx  = word_nx;
          cnt_nx   = cnt_inc;
          state_nx = (cnt_inc == '0) ? IDLE : FILL;
        end
      end
      FULL_WAIT, FLUSH_WAIT: begin
        if (slot_free) begin
          load      = 1'b1;
          load_word = sreg;
          load_cnt  = cnt;
          sreg_nx   = '0;
          cnt_nx    = '0;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
    end
  end

  // Output slot: a new load wins over the clear caused by a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_cnt   <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= load_word;
      dout_cnt   <= load_cnt;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_result_packer.sv
`default_nettype none
// Bench for mux_result_packer: directed scenarios plus random traffic against
// a bit-list transaction model; LSB-first and MSB-first instances in parallel.
module tb_mux_result_packer;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst, w, w_valid, flush, dout_ready;
  logic          wr_l, wr_m, dv_l, dv_m;
  logic [W-1:0]  d_l, d_m;
  logic [CW-1:0] c_l, c_m;

  int total = 0;
  int bad   = 0;

  // Transaction model state
  bit           bits[$];
  bit           waiting;
  logic [W-1:0] wait_word, m_word;
  int           wait_cnt, m_cnt;
  bit           m_valid;

  always #5 clk = ~clk;

  mux_result_packer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .w(w), .w_valid(w_valid), .w_ready(wr_l),
    .flush(flush), .dout(d_l), .dout_cnt(c_l), .dout_valid(dv_l),
    .dout_ready(dout_ready)
  );

  mux_result_packer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .w(w), .w_valid(w_valid), .w_ready(wr_m),
    .flush(flush), .dout(d_m), .dout_cnt(c_m), .dout_valid(dv_m),
    .dout_ready(dout_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = x[i];
    return r;
  endfunction

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] r = '0;
    foreach (bits[k]) r[k] = bits[k];
    return r;
  endfunction

  task automatic model_reset();
    bits.delete();
    waiting   = 0;
    wait_word = '0;
    wait_cnt  = 0;
    m_word    = '0;
    m_cnt     = 0;
    m_valid   = 0;
  endtask

  task automatic model_edge();
    bit free;
    free = !m_valid || dout_ready;
    if (m_valid && dout_ready) m_valid = 0;
    if (waiting) begin
      if (free) begin
        m_valid = 1; m_word = wait_word; m_cnt = wait_cnt; waiting = 0;
      end
    end else begin
      if (w_valid) bits.push_back(w);
      if (bits.size() == W || (flush && bits.size() > 0)) begin
        if (free) begin
          m_valid = 1; m_word = pack_bits(); m_cnt = bits.size();
        end else begin
          waiting = 1; wait_word = pack_bits(); wait_cnt = bits.size();
        end
        bits.delete();
      end
    end
  endtask

  task automatic compare_all();
    check("w_ready_lsb", wr_l, !waiting);
    check("w_ready_msb", wr_m, !waiting);
    check("valid_lsb", dv_l, m_valid);
    check("valid_msb", dv_m, m_valid);
    if (m_valid) begin
      check("dout_lsb", d_l, m_word);
      check("dout_msb", d_m, rev(m_word));
      check("cnt_lsb", c_l, m_cnt);
      check("cnt_msb", c_m, m_cnt);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit vv, input bit ww, input bit ff, input bit rr);
    w_valid = vv; w = ww; flush = ff; dout_ready = rr;
    step();
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1; w = 0; w_valid = 0; flush = 0; dout_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", dv_l, 0);
    check("rst_dout", d_l, 0);
    check("rst_cnt", c_l, 0);
    check("rst_wready", wr_l, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Basic packing, both bit orders
    pat = 8'h4D;
    for (int k = 0; k < 8; k++) drive(1, pat[k], 0, 1);
    check("t1_lsb", d_l, 8'h4D);
    check("t1_msb", d_m, 8'hB2);
    check("t1_cnt", c_l, 8);
    check("t1_valid", dv_l, 1);
    drive(0, 0, 0, 1);
    check("t1_onecycle", dv_l, 0);

    // Backpressure: second word waits in FULL_WAIT
    for (int k = 0; k < 16; k++) drive(1, 1, 0, 0);
    check("t3_wready_low", wr_l, 0);
    check("t3_held", d_l, 8'hFF);
    drive(0, 0, 0, 1);
    check("t3_second_valid", dv_l, 1);
    check("t3_second_word", d_l, 8'hFF);
    check("t3_wready_back", wr_l, 1);
    drive(0, 0, 0, 1);

    // Partial flush, then flush with nothing pending
    drive(1, 1, 0, 1); drive(1, 1, 0, 1); drive(1, 0, 0, 1);
    drive(0, 0, 1, 1);
    check("t4_lsb", d_l, 8'h03);
    check("t4_msb", d_m, 8'hC0);
    check("t4_cnt", c_l, 3);
    drive(0, 0, 1, 1);
    check("t4_empty_flush", dv_l, 0);

    // Flush coinciding with the completing bit
    for (int k = 0; k < 7; k++) drive(1, 1, 0, 1);
    drive(1, 1, 1, 1);
    check("t5_cnt", c_l, 8);
    check("t5_valid", dv_l, 1);
    drive(0, 0, 0, 1);
    check("t5_no_extra", dv_l, 0);

    // Async reset with a held word and 5 partial bits
    for (int k = 0; k < 13; k++) drive(1, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_valid", dv_l, 0);
    check("t6_dout", d_l, 0);
    check("t6_cnt", c_l, 0);
    check("t6_wready", wr_l, 0);
    model_reset();
    w_valid = 0; flush = 0; dout_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    pat = 8'hA5;
    for (int k = 0; k < 8; k++) drive(1, pat[k], 0, 1);
    check("t6_fresh_lsb", d_l, 8'hA5);
    check("t6_fresh_msb", d_m, 8'hA5);

    // Random traffic
    repeat (1500) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) < 3);
    end
    repeat (4) drive(0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
